// File: rtl/tboom_rename_pkg.sv
// rtl/tboom_rename_pkg.sv - shared types and sizes for the two-wide rename map table
package tboom_rename_pkg;

    localparam int ARCH_REG_WIDTH = 5;
    localparam int N_ARCH_REGS    = 32;
    localparam int PREG_W         = 6;
    localparam int N_CKPT         = 8;

    typedef logic [PREG_W-1:0]         preg_t;
    typedef logic [ARCH_REG_WIDTH-1:0] areg_t;

    typedef struct packed {
        logic  valid;
        preg_t prs1;
        preg_t prs2;
        preg_t pdst;
        preg_t stale_pdst;
    } rename_uop_t;

    // x0 is hardwired, so an instruction targeting it never consumes a preg.
    function automatic logic needs_alloc(input logic valid, input logic rd_valid, input areg_t rd);
        return valid & rd_valid & (rd != '0);
    endfunction

endpackage

// File: rtl/tboom_rmt_checkpoint_store.sv
// rtl/tboom_rmt_checkpoint_store.sv - snapshot slots holding full copies of the rename map
//
// Purpose: DEPTH snapshots of an NREGS x W map. One write port (checkpoint) and
// one combinational read port (restore), both indexed by slot position.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (all slots -> identity)
//   wr_en, wr_pos     write the map presented on wr_map into slot wr_pos
//   wr_map            map to snapshot
//   rd_pos, rd_map    combinational read of slot rd_pos
module tboom_rmt_checkpoint_store #(
    parameter int DEPTH = 8,
    parameter int NREGS = 32,
    parameter int W     = 6,
    localparam int POS_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [POS_W-1:0]           wr_pos,
    input  logic [NREGS-1:0][W-1:0]    wr_map,
    input  logic [POS_W-1:0]           rd_pos,
    output logic [NREGS-1:0][W-1:0]    rd_map
);

    logic [DEPTH-1:0][NREGS-1:0][W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (wr_en) begin
            slot_d[wr_pos] = wr_map;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int r = 0; r < NREGS; r++) begin
                    slot_q[s][r] <= W'(r);
                end
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    assign rd_map = slot_q[rd_pos];

endmodule

// File: rtl/tboom_rename_map_table.sv
// rtl/tboom_rename_map_table.sv - two-wide rename map table with checkpoints and registered output
//
// Purpose: renames an instruction pair (i0 older, i1 younger) against the
// speculative map, pops pdsts from the freelist, reports stale pdsts and
// presents the renamed pair to dispatch one cycle later.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   i0_*/i1_*                           decoded instruction pair
//   fl_i0_data, fl_i1_data              combinational freelist heads
//   fl_empty, fl_one_remaining          freelist occupancy
//   fl_i0_read_enable, fl_i1_read_enable freelist pops
//   in_ready                            bundle accepted this cycle
//   out_ready, out_valid, o_*           registered dispatch interface
//   checkpoint, restore, checkpoint_restore_pos  map snapshot control
module tboom_rename_map_table
    import tboom_rename_pkg::*;
#(
    parameter int ARCH_REGS        = 32,
    parameter int PREG_WIDTH       = 6,
    parameter int CHECKPOINT_DEPTH = 8,
    localparam int POS_W           = $clog2(CHECKPOINT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i0_valid,
    input  logic                  i1_valid,
    input  logic [4:0]            i0_rs1,
    input  logic [4:0]            i0_rs2,
    input  logic [4:0]            i1_rs1,
    input  logic [4:0]            i1_rs2,
    input  logic [4:0]            i0_rd,
    input  logic [4:0]            i1_rd,
    input  logic                  i0_rd_valid,
    input  logic                  i1_rd_valid,
    input  logic [PREG_WIDTH-1:0] fl_i0_data,
    input  logic [PREG_WIDTH-1:0] fl_i1_data,
    input  logic                  fl_empty,
    input  logic                  fl_one_remaining,
    output logic                  fl_i0_read_enable,
    output logic                  fl_i1_read_enable,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic                  o_i0_valid,
    output logic                  o_i1_valid,
    output logic [PREG_WIDTH-1:0] o_i0_prs1,
    output logic [PREG_WIDTH-1:0] o_i0_prs2,
    output logic [PREG_WIDTH-1:0] o_i1_prs1,
    output logic [PREG_WIDTH-1:0] o_i1_prs2,
    output logic [PREG_WIDTH-1:0] o_i0_pdst,
    output logic [PREG_WIDTH-1:0] o_i1_pdst,
    output logic [PREG_WIDTH-1:0] o_i0_stale_pdst,
    output logic [PREG_WIDTH-1:0] o_i1_stale_pdst,
    input  logic                  checkpoint,
    input  logic                  restore,
    input  logic [POS_W-1:0]      checkpoint_restore_pos
);

    logic [ARCH_REGS-1:0][PREG_WIDTH-1:0] map_q, map_d;
    logic [ARCH_REGS-1:0][PREG_WIDTH-1:0] ckpt_map;
    logic                                 out_valid_q, out_valid_d;
    rename_uop_t                          out0_q, out0_d, out1_q, out1_d;

    logic        a0, a1, stall_fl, stall_out, ready, accept;
    logic        i1_dst_hit;
    rename_uop_t uop0, uop1;

    always_comb begin
        a0 = needs_alloc(i0_valid, i0_rd_valid, i0_rd);
        a1 = needs_alloc(i1_valid, i1_rd_valid, i1_rd);

        // A pair needs two free entries; any allocation needs at least one.
        stall_fl  = (a0 & a1 & (fl_one_remaining | fl_empty)) | ((a0 | a1) & fl_empty);
        stall_out = out_valid_q & ~out_ready;
        ready     = ~restore & ~stall_fl & ~stall_out;
        accept    = ready & (i0_valid | i1_valid);

        // i1 must observe i0's new mapping when it reads or overwrites i0's rd.
        i1_dst_hit = a0 & (i1_rd == i0_rd);

        uop0 = '0;
        if (i0_valid) begin
            uop0.valid      = 1'b1;
            uop0.prs1       = map_q[i0_rs1];
            uop0.prs2       = map_q[i0_rs2];
            uop0.pdst       = a0 ? fl_i0_data : '0;
            uop0.stale_pdst = a0 ? map_q[i0_rd] : '0;
        end

        uop1 = '0;
        if (i1_valid) begin
            uop1.valid      = 1'b1;
            uop1.prs1       = (a0 & (i1_rs1 == i0_rd)) ? fl_i0_data : map_q[i1_rs1];
            uop1.prs2       = (a0 & (i1_rs2 == i0_rd)) ? fl_i0_data : map_q[i1_rs2];
            uop1.pdst       = a1 ? fl_i1_data : '0;
            uop1.stale_pdst = a1 ? (i1_dst_hit ? fl_i0_data : map_q[i1_rd]) : '0;
        end

        map_d       = map_q;
        out_valid_d = out_valid_q;
        out0_d      = out0_q;
        out1_d      = out1_q;

        if (restore) begin
            map_d       = ckpt_map;
            out_valid_d = 1'b0;
            out0_d      = '0;
            out1_d      = '0;
        end else if (accept) begin
            // i1 written last so it wins when both target the same rd.
            if (a0) map_d[i0_rd] = fl_i0_data;
            if (a1) map_d[i1_rd] = fl_i1_data;
            out_valid_d = 1'b1;
            out0_d      = uop0;
            out1_d      = uop1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out0_d      = '0;
            out1_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                map_q[r] <= PREG_WIDTH'(r);
            end
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
        end else begin
            map_q       <= map_d;
            out_valid_q <= out_valid_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
        end
    end

    // Snapshot takes the map as it was at the start of the cycle (map_q).
    tboom_rmt_checkpoint_store #(
        .DEPTH (CHECKPOINT_DEPTH),
        .NREGS (ARCH_REGS),
        .W     (PREG_WIDTH)
    ) u_ckpt (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (checkpoint & ~restore),
        .wr_pos (checkpoint_restore_pos),
        .wr_map (map_q),
        .rd_pos (checkpoint_restore_pos),
        .rd_map (ckpt_map)
    );

    assign in_ready          = ready;
    assign fl_i0_read_enable = ready & a0;
    assign fl_i1_read_enable = ready & a1;

    assign out_valid       = out_valid_q;
    assign o_i0_valid      = out0_q.valid;
    assign o_i0_prs1       = out0_q.prs1;
    assign o_i0_prs2       = out0_q.prs2;
    assign o_i0_pdst       = out0_q.pdst;
    assign o_i0_stale_pdst = out0_q.stale_pdst;
    assign o_i1_valid      = out1_q.valid;
    assign o_i1_prs1       = out1_q.prs1;
    assign o_i1_prs2       = out1_q.prs2;
    assign o_i1_pdst       = out1_q.pdst;
    assign o_i1_stale_pdst = out1_q.stale_pdst;

endmodule

// File: tb/tb_tboom_rename_map_table.sv
// tb/tb_tboom_rename_map_table.sv - self-checking bench for tboom_rename_map_table
module tb_tboom_rename_map_table;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i0_valid, i1_valid, i0_rd_valid, i1_rd_valid;
    logic [4:0] i0_rs1, i0_rs2, i1_rs1, i1_rs2, i0_rd, i1_rd;
    logic [5:0] fl_i0_data, fl_i1_data;
    logic       fl_empty, fl_one_remaining;
    logic       fl_i0_read_enable, fl_i1_read_enable, in_ready;
    logic       out_ready, out_valid, o_i0_valid, o_i1_valid;
    logic [5:0] o_i0_prs1, o_i0_prs2, o_i1_prs1, o_i1_prs2;
    logic [5:0] o_i0_pdst, o_i1_pdst, o_i0_stale_pdst, o_i1_stale_pdst;
    logic       checkpoint, restore;
    logic [2:0] pos;

    always #5 clk = ~clk;

    tboom_rename_map_table dut (
        .clk(clk), .rst_n(rst_n),
        .i0_valid(i0_valid), .i1_valid(i1_valid),
        .i0_rs1(i0_rs1), .i0_rs2(i0_rs2), .i1_rs1(i1_rs1), .i1_rs2(i1_rs2),
        .i0_rd(i0_rd), .i1_rd(i1_rd), .i0_rd_valid(i0_rd_valid), .i1_rd_valid(i1_rd_valid),
        .fl_i0_data(fl_i0_data), .fl_i1_data(fl_i1_data),
        .fl_empty(fl_empty), .fl_one_remaining(fl_one_remaining),
        .fl_i0_read_enable(fl_i0_read_enable), .fl_i1_read_enable(fl_i1_read_enable),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .o_i0_valid(o_i0_valid), .o_i1_valid(o_i1_valid),
        .o_i0_prs1(o_i0_prs1), .o_i0_prs2(o_i0_prs2), .o_i1_prs1(o_i1_prs1), .o_i1_prs2(o_i1_prs2),
        .o_i0_pdst(o_i0_pdst), .o_i1_pdst(o_i1_pdst),
        .o_i0_stale_pdst(o_i0_stale_pdst), .o_i1_stale_pdst(o_i1_stale_pdst),
        .checkpoint(checkpoint), .restore(restore), .checkpoint_restore_pos(pos)
    );

    int vectors = 0;
    int miscompares = 0;
    int step = 0;

    // Reference model: architectural map, snapshot slots, expected dispatch slots.
    logic [5:0] ref_map [32];
    logic [5:0] ref_ckpt [8][32];
    logic       e_ov;
    logic       e_v [2];
    logic [5:0] e_prs1 [2], e_prs2 [2], e_pdst [2], e_stale [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    task automatic clear_out();
        e_ov = 1'b0;
        for (int s = 0; s < 2; s++) begin
            e_v[s] = 1'b0; e_prs1[s] = '0; e_prs2[s] = '0; e_pdst[s] = '0; e_stale[s] = '0;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            ref_map[r] = 6'(r);
            for (int s = 0; s < 8; s++) ref_ckpt[s][r] = 6'(r);
        end
        clear_out();
    endtask

    task automatic idle();
        i0_valid = 0; i1_valid = 0; i0_rd_valid = 0; i1_rd_valid = 0;
        i0_rs1 = 0; i0_rs2 = 0; i1_rs1 = 0; i1_rs2 = 0; i0_rd = 0; i1_rd = 0;
        fl_i0_data = 0; fl_i1_data = 0; fl_empty = 0; fl_one_remaining = 0;
        out_ready = 1; checkpoint = 0; restore = 0; pos = 0;
    endtask

    // Renames one instruction against a working copy of the map; the younger
    // slot is processed after the older one, which yields bypass and overwrite order.
    task automatic rename_slot(input int s, input logic v, input logic rdv, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic [5:0] fl,
                               inout logic [5:0] m [32]);
        e_v[s] = v; e_prs1[s] = '0; e_prs2[s] = '0; e_pdst[s] = '0; e_stale[s] = '0;
        if (v) begin
            e_prs1[s] = m[rs1];
            e_prs2[s] = m[rs2];
            if (rdv && rd != 0) begin
                e_pdst[s] = fl;
                e_stale[s] = m[rd];
                m[rd] = fl;
            end
        end
    endtask

    task automatic cycle();
        logic a0, a1, short, ir;
        logic [5:0] tmp [32];
        step++;
        #1;
        a0 = i0_valid && i0_rd_valid && (i0_rd != 0);
        a1 = i1_valid && i1_rd_valid && (i1_rd != 0);
        short = fl_empty ? (a0 || a1) : (fl_one_remaining && a0 && a1);
        ir = !restore && !short && !(e_ov && !out_ready);
        chk("in_ready", in_ready, ir);
        chk("fl_i0_read_enable", fl_i0_read_enable, ir && a0);
        chk("fl_i1_read_enable", fl_i1_read_enable, ir && a1);
        @(posedge clk);
        if (restore) begin
            for (int r = 0; r < 32; r++) ref_map[r] = ref_ckpt[pos][r];
            clear_out();
        end else begin
            if (checkpoint) for (int r = 0; r < 32; r++) ref_ckpt[pos][r] = ref_map[r];
            if (ir && (i0_valid || i1_valid)) begin
                for (int r = 0; r < 32; r++) tmp[r] = ref_map[r];
                rename_slot(0, i0_valid, i0_rd_valid, i0_rs1, i0_rs2, i0_rd, fl_i0_data, tmp);
                rename_slot(1, i1_valid, i1_rd_valid, i1_rs1, i1_rs2, i1_rd, fl_i1_data, tmp);
                for (int r = 0; r < 32; r++) ref_map[r] = tmp[r];
                e_ov = 1'b1;
            end else if (out_ready) begin
                clear_out();
            end
        end
        @(negedge clk);
        chk_outputs();
    endtask

    task automatic chk_outputs();
        chk("out_valid", out_valid, e_ov);
        chk("o_i0_valid", o_i0_valid, e_v[0]);
        chk("o_i0_prs1", o_i0_prs1, e_prs1[0]);
        chk("o_i0_prs2", o_i0_prs2, e_prs2[0]);
        chk("o_i0_pdst", o_i0_pdst, e_pdst[0]);
        chk("o_i0_stale", o_i0_stale_pdst, e_stale[0]);
        chk("o_i1_valid", o_i1_valid, e_v[1]);
        chk("o_i1_prs1", o_i1_prs1, e_prs1[1]);
        chk("o_i1_prs2", o_i1_prs2, e_prs2[1]);
        chk("o_i1_pdst", o_i1_pdst, e_pdst[1]);
        chk("o_i1_stale", o_i1_stale_pdst, e_stale[1]);
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    endfunction

    task automatic rand_inputs();
        i0_valid = ($urandom_range(0, 7) != 0); i1_valid = ($urandom_range(0, 3) != 0);
        i0_rd_valid = ($urandom_range(0, 4) != 0); i1_rd_valid = ($urandom_range(0, 4) != 0);
        i0_rs1 = rreg(); i0_rs2 = rreg(); i1_rs1 = rreg(); i1_rs2 = rreg();
        i0_rd = rreg(); i1_rd = rreg();
        fl_i0_data = 6'($urandom); fl_i1_data = 6'($urandom);
        fl_empty = ($urandom_range(0, 9) == 0); fl_one_remaining = ($urandom_range(0, 5) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        checkpoint = ($urandom_range(0, 7) == 0); restore = ($urandom_range(0, 15) == 0);
        pos = 3'($urandom);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_outputs();
        rst_n = 1'b1;

        // Single i0 rename: x5 <- x1, x2 gets preg 32.
        idle(); i0_valid = 1; i0_rd_valid = 1; i0_rs1 = 1; i0_rs2 = 2; i0_rd = 5; fl_i0_data = 32;
        cycle();
        chk("d_i0_prs1", o_i0_prs1, 1); chk("d_i0_pdst", o_i0_pdst, 32); chk("d_i0_stale", o_i0_stale_pdst, 5);

        // Pair with i1 reading i0's destination.
        idle(); i0_valid = 1; i0_rd_valid = 1; i0_rs1 = 1; i0_rd = 3; fl_i0_data = 33;
        i1_valid = 1; i1_rd_valid = 1; i1_rs1 = 3; i1_rs2 = 3; i1_rd = 4; fl_i1_data = 34;
        cycle();
        chk("d_i1_prs1", o_i1_prs1, 33); chk("d_i1_prs2", o_i1_prs2, 33);
        chk("d_i1_pdst", o_i1_pdst, 34); chk("d_i1_stale", o_i1_stale_pdst, 4);

        // Both slots write x7; i1 wins and sees i0's pdst as stale.
        idle(); i0_valid = 1; i0_rd_valid = 1; i0_rd = 7; fl_i0_data = 35;
        i1_valid = 1; i1_rd_valid = 1; i1_rd = 7; fl_i1_data = 36;
        cycle();
        chk("d_x7_stale", o_i1_stale_pdst, 35);
        idle(); i0_valid = 1; i0_rs1 = 7; cycle();
        chk("d_x7_read", o_i0_prs1, 36);

        // One free entry: pair stalls, lone i1 allocation proceeds.
        idle(); fl_one_remaining = 1; i0_valid = 1; i0_rd_valid = 1; i0_rd = 8; fl_i0_data = 37;
        i1_valid = 1; i1_rd_valid = 1; i1_rd = 9; fl_i1_data = 38;
        cycle();
        i0_valid = 0; cycle();
        chk("d_i1_only_pdst", o_i1_pdst, 38);

        // Checkpoint x5->32, overwrite x5, restore, read back.
        idle(); checkpoint = 1; pos = 2; cycle();
        idle(); i0_valid = 1; i0_rd_valid = 1; i0_rd = 5; fl_i0_data = 40; cycle();
        idle(); restore = 1; pos = 2; cycle();
        chk("d_restore_ov", out_valid, 0);
        idle(); i0_valid = 1; i0_rs1 = 5; cycle();
        chk("d_restore_x5", o_i0_prs1, 32);

        // Dispatch backpressure, then asynchronous reset in the middle of it.
        idle(); i0_valid = 1; i0_rd_valid = 1; i0_rd = 10; fl_i0_data = 41; cycle();
        for (int k = 0; k < 3; k++) begin
            idle(); out_ready = 0; i0_valid = 1; i0_rd_valid = 1; i0_rd = 11; fl_i0_data = 42; cycle();
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        step++;
        chk("reset_mid_out_valid", out_valid, 0);
        chk("reset_mid_o_i0_pdst", o_i0_pdst, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); i0_valid = 1; i0_rs1 = 5; i0_rs2 = 10; i1_valid = 1; i1_rs1 = 7; i1_rs2 = 3; cycle();
        chk("d_ident_x5", o_i0_prs1, 5); chk("d_ident_x7", o_i1_prs1, 7);

        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
